// File: rtl/hazard3_power_seq_if.sv
// hazard3_power_seq_if: req/ack power fabric, CSR and core sleep/wake signals of the sequencer.
interface hazard3_power_seq_if #(
    parameter int N_DOMAINS = 2,
    parameter int W_TIMEOUT = 8
);
    logic [N_DOMAINS-1:0] pwrup_req;
    logic [N_DOMAINS-1:0] pwrup_ack;
    logic [N_DOMAINS-1:0] keep_on;
    logic [W_TIMEOUT-1:0] timeout_limit;
    logic                 clk_en;
    logic                 allow_sleep;
    logic                 allow_power_down;
    logic                 frontend_pwrdown_ok;
    logic                 sleeping;
    logic                 wake_req;
    logic                 stall_release;
    logic                 ack_timeout;

    modport master (
        output pwrup_req, clk_en, stall_release, ack_timeout,
        input  pwrup_ack, keep_on, timeout_limit, allow_sleep, allow_power_down,
               frontend_pwrdown_ok, sleeping, wake_req
    );

    modport slave (
        input  pwrup_req, clk_en, stall_release, ack_timeout,
        output pwrup_ack, keep_on, timeout_limit, allow_sleep, allow_power_down,
               frontend_pwrdown_ok, sleeping, wake_req
    );
endinterface

// File: rtl/hazard3_power_seq.sv
// hazard3_power_seq: orders per-domain 4-phase power-down/up around core sleep,
// with keep-on mask, ack timeouts and a clock-gate settle delay before release.
module hazard3_power_seq #(
    parameter int N_DOMAINS   = 2,
    parameter int W_TIMEOUT   = 8,
    parameter int CLKEN_DELAY = 1
) (
    input logic                 clk_always_on,
    input logic                 rst_n,
    hazard3_power_seq_if.master pwr
);
    localparam int IW = N_DOMAINS > 1 ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [2:0] {S_AWAKE, S_PWRDN, S_ASLEEP, S_PWRUP, S_SETTLE} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N_DOMAINS-1:0] req_q, req_d, dn_mask_q, dn_mask_d, sleep_mask;
    logic [W_TIMEOUT-1:0] cnt_q, cnt_d;
    logic                 clk_en_q, clk_en_d, stall_q, stall_d, tmo_q, tmo_d;
    logic                 on, ack_ok, timed_out, step_done;

    always_comb begin
        on         = dn_mask_q[idx_q];
        ack_ok     = pwr.pwrup_ack[idx_q] == (state_q == S_PWRUP);
        timed_out  = on && !ack_ok && |pwr.timeout_limit && cnt_q == pwr.timeout_limit;
        step_done  = !on || ack_ok || timed_out;
        sleep_mask = pwr.allow_power_down ? ~pwr.keep_on : '0;
        state_d    = state_q;
        idx_d      = idx_q;
        req_d      = req_q;
        dn_mask_d  = dn_mask_q;
        clk_en_d   = clk_en_q;
        stall_d    = 1'b0;
        tmo_d      = 1'b0;
        // Saturate so a disabled timeout can wait forever without wrapping
        cnt_d      = &cnt_q ? cnt_q : cnt_q + W_TIMEOUT'(1);
        case (state_q)
            S_AWAKE: begin
                if (pwr.sleeping && !stall_q) begin
                    if (pwr.wake_req) begin
                        stall_d = 1'b1;
                    end else if ((pwr.allow_sleep || pwr.allow_power_down) && pwr.frontend_pwrdown_ok) begin
                        clk_en_d  = !pwr.allow_sleep;
                        dn_mask_d = sleep_mask;
                        idx_d     = IW'(N_DOMAINS - 1);
                        cnt_d     = '0;
                        state_d   = |sleep_mask ? S_PWRDN : S_ASLEEP;
                    end
                end
            end
            S_PWRDN: begin
                if (pwr.wake_req) begin
                    clk_en_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_PWRUP;
                end else begin
                    if (on) req_d[idx_q] = 1'b0;
                    if (step_done) begin
                        tmo_d   = timed_out;
                        cnt_d   = '0;
                        idx_d   = idx_q == '0 ? idx_q : idx_q - IW'(1);
                        state_d = idx_q == '0 ? S_ASLEEP : S_PWRDN;
                    end
                end
            end
            S_ASLEEP: begin
                if (pwr.wake_req) begin
                    clk_en_d = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = |dn_mask_q ? S_PWRUP : S_SETTLE;
                end
            end
            S_PWRUP: begin
                if (on) req_d[idx_q] = 1'b1;
                if (step_done) begin
                    tmo_d   = timed_out;
                    cnt_d   = '0;
                    idx_d   = idx_q == IW'(N_DOMAINS - 1) ? idx_q : idx_q + IW'(1);
                    state_d = idx_q == IW'(N_DOMAINS - 1) ? S_SETTLE : S_PWRUP;
                end
            end
            S_SETTLE: begin
                if (cnt_q == W_TIMEOUT'(CLKEN_DELAY - 1)) begin
                    stall_d = 1'b1;
                    state_d = S_AWAKE;
                end
            end
            default: state_d = S_AWAKE;
        endcase
    end

    always_ff @(posedge clk_always_on or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_AWAKE;
            idx_q     <= '0;
            req_q     <= '1;
            dn_mask_q <= '0;
            cnt_q     <= '0;
            clk_en_q  <= 1'b1;
            stall_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            req_q     <= req_d;
            dn_mask_q <= dn_mask_d;
            cnt_q     <= cnt_d;
            clk_en_q  <= clk_en_d;
            stall_q   <= stall_d;
            tmo_q     <= tmo_d;
        end
    end

    assign pwr.pwrup_req     = req_q;
    assign pwr.clk_en        = clk_en_q;
    assign pwr.stall_release = stall_q;
    assign pwr.ack_timeout   = tmo_q;
endmodule

// File: doc/hazard3_power_seq.md
# hazard3_power_seq

Multi-domain power sequencer for Hazard3. It generalises the single-domain wake/sleep controller to `N_DOMAINS` 4-phase req/ack power domains with several added behaviours:
- ordered power-down and power-up;
- a per-domain keep-on mask;
- ack timeouts;
- a programmable clock-gate settle delay before the pipeline is released.

It sits in the always-on clock domain, between the core's sleep/wake signals and the SoC power fabric.

## Interface
Parameters:
- `N_DOMAINS`, 2: number of power domains; legal range 1 to 16.
- `W_TIMEOUT`, 8: width of the ack-timeout counter and of the limit input.
- `CLKEN_DELAY`, 1: cycles between `clk_en` rising and `stall_release` firing; legal range 1 to 7.

Ports:
- `clk_always_on  in  1`: the module's only clock. Reset is asynchronous and active-low.
- `rst_n  in  1`: asynchronous, active-low reset.
- `pwrup_req  out  N_DOMAINS`: per-domain power request; 4-phase with `pwrup_ack`.
- `pwrup_ack  in  N_DOMAINS`: per-domain acknowledge; assumed high at reset.
- `clk_en  out  1`: enable for the processor clock gate.
- `allow_sleep  in  1`: CSR control; gate the clock while asleep.
- `allow_power_down  in  1`: CSR control; drop domain requests while asleep.
- `keep_on  in  N_DOMAINS`: CSR mask; a set bit keeps that domain powered during sleep.
- `timeout_limit  in  W_TIMEOUT`: ack wait limit in cycles; 0 disables the timeout.
- `frontend_pwrdown_ok  in  1`: instruction fetch is quiet.
- `sleeping  in  1`: core is stalled on WFI or block.
- `wake_req  in  1`: level wake request, already qualified by the core.
- `stall_release  out  1`: one-cycle pulse that releases the stall.
- `ack_timeout  out  1`: one-cycle pulse when a domain step times out.

## Operation
- States: `S_AWAKE`, `S_PWRDN`, `S_ASLEEP`, `S_PWRUP`, `S_SETTLE`. A step index `idx` (clog2(N_DOMAINS) bits, minimum 1 bit) tracks the current domain.
- Reset values:
  - state = `S_AWAKE`;
  - `pwrup_req` = all ones;
  - `clk_en` = 1;
  - `stall_release` = 0;
  - `ack_timeout` = 0;
  - `idx` = 0;
  - timeout counter = 0;
  - `dn_mask` = 0.
- `S_AWAKE`, evaluated only when `sleeping` is high and `stall_release` is low:
  - `wake_req` high: pulse `stall_release` and stay in `S_AWAKE` (fall-through).
  - Else, if (`allow_sleep` | `allow_power_down`) and `frontend_pwrdown_ok`:
    - set `clk_en` <= !`allow_sleep`;
    - latch `dn_mask` <= ~`keep_on` if `allow_power_down`, else 0;
    - if `dn_mask` is nonzero, go to `S_PWRDN` with `idx` = N_DOMAINS-1; otherwise go to `S_ASLEEP`.
  - Otherwise remain in `S_AWAKE`.
- `S_PWRDN`: domains are powered down in descending index order.
  - On step entry, if `dn_mask[idx]` is set, clear `pwrup_req[idx]` and clear the counter.
  - The step completes when `pwrup_ack[idx]` is 0, or on timeout. A masked-off step completes after exactly 1 cycle.
  - On completion: if `idx` = 0, go to `S_ASLEEP`; otherwise decrement `idx`.
- `S_ASLEEP`: on `wake_req`, set `clk_en` <= 1.
  - If `dn_mask` is nonzero, go to `S_PWRUP` with `idx` = 0.
  - Otherwise go to `S_SETTLE`.
- `S_PWRUP`: domains are powered up in ascending index order, mirroring `S_PWRDN`.
  - On step entry, set `pwrup_req[idx]` for masked-on domains.
  - The step completes when `pwrup_ack[idx]` is 1, or on timeout.
  - After step N_DOMAINS-1, go to `S_SETTLE`.
- `S_SETTLE`: count `CLKEN_DELAY` cycles, then pulse `stall_release` and go to `S_AWAKE`.
- Abort: `wake_req` high in `S_PWRDN` at index k does the following:
  - `clk_en` <= 1;
  - go to `S_PWRUP` at `idx` = k, re-asserting `pwrup_req[k]`;
  - only domains k..N-1 are restored.
- Timeout:
  - The counter increments each cycle of a waiting step.
  - When it equals `timeout_limit` (nonzero), `ack_timeout` pulses and the step completes regardless of ack.
  - The counter is W_TIMEOUT bits wide and never wraps within a step.
- CSR inputs are sampled only at sleep entry (`dn_mask`). Changes to `keep_on` mid-sequence have no effect.
- `allow_power_down` falling while asleep does not skip the power-up sequence.

## Timing
- Fall-through: if `sleeping` and `wake_req` are both high in cycle t, `stall_release` is high in cycle t+1.
- `stall_release` never pulses in two consecutive cycles.
- `pwrup_req` changes exactly 1 cycle after step entry.
- Minimum step length:
  - 1 cycle if ack is already at the target level in the first cycle the step is evaluated;
  - ack is registered by the requester, so the typical step length is 2 or more cycles.
- Clock-gate-only sleep (`dn_mask` = 0):
  - wake latency is `CLKEN_DELAY`+1 cycles from `wake_req` to `stall_release`;
  - `clk_en` rises 1 cycle after `wake_req`.
- Asserting `rst_n` low mid-sequence immediately forces the reset values. All requests are re-asserted, and `pwrup_ack` is assumed to be high when reset is released.

## Test plan
- Fall-through: `sleeping` = 1 and `wake_req` = 1 together -> `stall_release` = 1 on the next cycle; `clk_en` and `pwrup_req` unchanged.
- Full cycle, N_DOMAINS = 3, `allow_power_down` = 1, `allow_sleep` = 1, `keep_on` = 0, ack follows req after 2 cycles:
  - `pwrup_req` drops 2, 1, 0 in order; `clk_en` = 0;
  - on `wake_req`, `pwrup_req` rises 0, 1, 2;
  - `stall_release` fires `CLKEN_DELAY`+1 cycles after ack[2] rises.
- `keep_on` = 3'b010: `pwrup_req[1]` stays 1 throughout; its step takes 1 cycle in each direction.
- Abort: `wake_req` pulsed while `idx` = 1 in `S_PWRDN` (N = 3) -> `pwrup_req[1]` and `pwrup_req[2]` are restored; `pwrup_req[0]` never drops; exactly one `stall_release`.
- Timeout: `timeout_limit` = 4 with ack[0] stuck high -> `ack_timeout` pulses 4 cycles after `pwrup_req[0]` falls; sequencer reaches `S_ASLEEP`. With `timeout_limit` = 0 it waits indefinitely.
- Reset mid-`S_PWRUP`: `rst_n` low -> `pwrup_req` = 3'b111, `clk_en` = 1, `stall_release` = 0 asynchronously.
